// File: rtl/clk3_result_arbiter.sv
// Round-robin scheduler that funnels single-word results from pNUM_SRC sources
// onto one registered valid/ready port, with one buffer slot and a sticky overflow bit per source.
module clk3_result_arbiter #(
  parameter int pDATA_WIDTH = 60,
  parameter int pNUM_SRC    = 4,
  parameter int pID_WIDTH   = 2
) (
  input  logic                            clk_3,
  input  logic                            rst_n,
  input  logic [pNUM_SRC-1:0]             src_flag,
  input  logic [pNUM_SRC*pDATA_WIDTH-1:0] src_data,
  input  logic                            out_ready,
  input  logic                            clr_overflow,
  output logic                            out_valid,
  output logic [pDATA_WIDTH-1:0]          out,
  output logic [pID_WIDTH-1:0]            out_id,
  output logic [pNUM_SRC-1:0]             src_busy,
  output logic [pNUM_SRC-1:0]             overflow
);

  localparam int IDX_W = (pNUM_SRC > 1) ? $clog2(pNUM_SRC) : 1;

  typedef enum logic {
    ST_IDLE,
    ST_VALID
  } state_e;

  state_e                 state_q, state_d;
  logic [pDATA_WIDTH-1:0] out_q, out_d;
  logic [pID_WIDTH-1:0]   out_id_q, out_id_d;
  logic [IDX_W-1:0]       last_grant_q, last_grant_d;
  logic [pNUM_SRC-1:0]    slot_full_q, slot_full_d;
  logic [pNUM_SRC-1:0]    overflow_q, overflow_d;
  logic [pDATA_WIDTH-1:0] slot_data_q [pNUM_SRC];

  logic                   can_load;
  logic                   grant_found;
  logic [IDX_W-1:0]       grant_idx;
  logic [IDX_W-1:0]       cand;
  logic [pNUM_SRC-1:0]    grant_vec;
  logic [pNUM_SRC-1:0]    load_vec;
  logic [pNUM_SRC-1:0]    ovf_set;

  // Winner search: first full slot after the last grant, wrapping around.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int off = 1; off <= pNUM_SRC; off++) begin
      cand = IDX_W'((int'(last_grant_q) + off) % pNUM_SRC);
      if (!grant_found && slot_full_q[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    can_load  = (state_q == ST_IDLE) || out_ready;
    grant_vec = '0;
    if (can_load && grant_found) grant_vec[grant_idx] = 1'b1;

    // A slot drained on this edge can take a new word on the same edge.
    slot_full_d = slot_full_q;
    load_vec    = '0;
    for (int i = 0; i < pNUM_SRC; i++) begin
      if (src_flag[i] && (!slot_full_q[i] || grant_vec[i])) begin
        load_vec[i]    = 1'b1;
        slot_full_d[i] = 1'b1;
      end else if (grant_vec[i]) begin
        slot_full_d[i] = 1'b0;
      end
    end

    ovf_set    = src_flag & slot_full_q & ~grant_vec;
    overflow_d = clr_overflow ? ovf_set : (overflow_q | ovf_set);

    state_d      = state_q;
    out_d        = out_q;
    out_id_d     = out_id_q;
    last_grant_d = last_grant_q;
    if (can_load) begin
      if (grant_found) begin
        state_d      = ST_VALID;
        out_d        = slot_data_q[grant_idx];
        out_id_d     = pID_WIDTH'(grant_idx);
        last_grant_d = grant_idx;
      end else begin
        state_d  = ST_IDLE;
        out_d    = '0;
        out_id_d = '0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_3 or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      out_q        <= '0;
      out_id_q     <= '0;
      last_grant_q <= IDX_W'(pNUM_SRC - 1);
      slot_full_q  <= '0;
      overflow_q   <= '0;
    end else begin
      state_q      <= state_d;
      out_q        <= out_d;
      out_id_q     <= out_id_d;
      last_grant_q <= last_grant_d;
      slot_full_q  <= slot_full_d;
      overflow_q   <= overflow_d;
    end
  end

  // NOTE: slot payloads are not reset; slot_full_q already marks them invalid after reset.
  always_ff @(posedge clk_3) begin
    for (int i = 0; i < pNUM_SRC; i++) begin
      if (load_vec[i]) slot_data_q[i] <= src_data[i*pDATA_WIDTH +: pDATA_WIDTH];
    end
  end

  assign out_valid = (state_q == ST_VALID);
  assign out       = out_q;
  assign out_id    = out_id_q;
  assign src_busy  = slot_full_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_clk3_result_arbiter.sv
// Directed bench for clk3_result_arbiter: a slot/queue-level model checked every cycle,
// plus literal expectations at key points of each scenario.
module tb_clk3_result_arbiter;

  localparam int N  = 4;
  localparam int W  = 60;
  localparam int IW = 2;

  logic              clk_3 = 1'b0;
  logic              rst_n;
  logic [N-1:0]      src_flag;
  logic [W-1:0]      sd [N];
  logic [N*W-1:0]    src_data;
  logic              out_ready;
  logic              clr_overflow;
  logic              out_valid;
  logic [W-1:0]      out;
  logic [IW-1:0]     out_id;
  logic [N-1:0]      src_busy;
  logic [N-1:0]      overflow;

  int n_vec  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  assign src_data = {sd[3], sd[2], sd[1], sd[0]};

  always #5 clk_3 = ~clk_3;

  clk3_result_arbiter #(
    .pDATA_WIDTH (W),
    .pNUM_SRC    (N),
    .pID_WIDTH   (IW)
  ) dut (
    .clk_3        (clk_3),
    .rst_n        (rst_n),
    .src_flag     (src_flag),
    .src_data     (src_data),
    .out_ready    (out_ready),
    .clr_overflow (clr_overflow),
    .out_valid    (out_valid),
    .out          (out),
    .out_id       (out_id),
    .src_busy     (src_busy),
    .overflow     (overflow)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: each source owns a one-deep buffer; the output takes the next
  // buffered word in rotating order whenever it is empty or being accepted.
  bit           m_full [N];
  logic [W-1:0] m_data [N];
  bit           m_valid;
  logic [W-1:0] m_out;
  int           m_id;
  int           m_last;
  bit [N-1:0]   m_ovf;

  always @(posedge clk_3 or negedge rst_n) begin
    if (!rst_n) begin
      foreach (m_full[i]) m_full[i] = 1'b0;
      m_valid = 1'b0;
      m_out   = '0;
      m_id    = 0;
      m_last  = N - 1;
      m_ovf   = '0;
    end else begin
      int         w;
      bit         take;
      bit [N-1:0] dropped;
      take = !m_valid || out_ready;
      w    = -1;
      if (take) begin
        for (int k = 1; k <= N; k++) begin
          if (w < 0 && m_full[(m_last + k) % N]) w = (m_last + k) % N;
        end
      end
      if (w >= 0) begin
        m_valid   = 1'b1;
        m_out     = m_data[w];
        m_id      = w;
        m_last    = w;
        m_full[w] = 1'b0;
      end else if (take) begin
        m_valid = 1'b0;
        m_out   = '0;
        m_id    = 0;
      end
      dropped = '0;
      for (int i = 0; i < N; i++) begin
        if (src_flag[i]) begin
          if (!m_full[i]) begin
            m_full[i] = 1'b1;
            m_data[i] = sd[i];
          end else begin
            dropped[i] = 1'b1;
          end
        end
      end
      m_ovf = clr_overflow ? dropped : (m_ovf | dropped);
    end
  end

  always @(negedge clk_3) begin
    if (rst_n && chk_en) begin
      bit [N-1:0] busy;
      foreach (m_full[i]) busy[i] = m_full[i];
      check("model.out_valid", 64'(out_valid), 64'(m_valid));
      check("model.out",       64'(out),       64'(m_out));
      check("model.out_id",    64'(out_id),    64'(m_id));
      check("model.src_busy",  64'(src_busy),  64'(busy));
      check("model.overflow",  64'(overflow),  64'(m_ovf));
    end
  end

  task automatic cyc(input logic [N-1:0] f, input logic rdy, input logic clr);
    src_flag     = f;
    out_ready    = rdy;
    clr_overflow = clr;
    @(posedge clk_3);
    @(negedge clk_3);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.out",       64'(out),       64'd0);
    check("rst.out_id",    64'(out_id),    64'd0);
    check("rst.src_busy",  64'(src_busy),  64'd0);
    check("rst.overflow",  64'(overflow),  64'd0);
    src_flag     = '0;
    out_ready    = 1'b0;
    clr_overflow = 1'b0;
    @(negedge clk_3);
    rst_n = 1'b1;
  endtask

  logic [IW-1:0] ids [6];

  initial begin
    rst_n        = 1'b0;
    src_flag     = '0;
    out_ready    = 1'b0;
    clr_overflow = 1'b0;
    foreach (sd[i]) sd[i] = '0;
    #12;
    check("init.out_valid", 64'(out_valid), 64'd0);
    check("init.src_busy",  64'(src_busy),  64'd0);
    @(negedge clk_3);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Single source: two-clock latency, one valid cycle.
    sd[2] = 60'h0ABC;
    cyc(4'b0100, 1'b1, 1'b0);
    check("single.busy",  64'(src_busy),  64'h4);
    check("single.idle",  64'(out_valid), 64'd0);
    cyc(4'b0000, 1'b1, 1'b0);
    check("single.valid", 64'(out_valid), 64'd1);
    check("single.out",   64'(out),       64'h0ABC);
    check("single.id",    64'(out_id),    64'd2);
    cyc(4'b0000, 1'b1, 1'b0);
    check("single.drop",  64'(out_valid), 64'd0);
    check("single.zero",  64'(out),       64'd0);

    // All four at once after reset: ids 0..3 back-to-back.
    do_reset();
    for (int i = 0; i < N; i++) sd[i] = 60'(16 + i);
    cyc(4'b1111, 1'b1, 1'b0);
    check("all.busy0", 64'(src_busy), 64'hF);
    for (int k = 0; k < N; k++) begin
      cyc(4'b0000, 1'b1, 1'b0);
      check("all.valid", 64'(out_valid), 64'd1);
      check("all.id",    64'(out_id),    64'(k));
      check("all.out",   64'(out),       64'(16 + k));
      check("all.busy",  64'(src_busy),  64'((4'hF << (k + 1)) & 4'hF));
    end
    cyc(4'b0000, 1'b1, 1'b0);
    check("all.end", 64'(out_valid), 64'd0);

    // Back-pressure: held stable, then accepted with no bubble.
    sd[1] = 60'h21;
    sd[2] = 60'h22;
    cyc(4'b0110, 1'b0, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      cyc(4'b0000, 1'b0, 1'b0);
      check("bp.hold.out", 64'(out),    64'h21);
      check("bp.hold.id",  64'(out_id), 64'd1);
    end
    cyc(4'b0000, 1'b1, 1'b0);
    check("bp.next.out", 64'(out),    64'h22);
    check("bp.next.id",  64'(out_id), 64'd2);
    cyc(4'b0000, 1'b1, 1'b0);

    // Overflow while slot 1 is stuck behind a stalled output.
    sd[0] = 60'h5;
    cyc(4'b0001, 1'b0, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0);
    sd[1] = 60'h1;
    cyc(4'b0010, 1'b0, 1'b0);
    sd[1] = 60'h2;
    cyc(4'b0010, 1'b0, 1'b0);
    check("ovf.set",  64'(overflow), 64'h2);
    check("ovf.busy", 64'(src_busy), 64'h2);
    cyc(4'b0000, 1'b1, 1'b0);
    check("ovf.kept", 64'(out), 64'h1);
    cyc(4'b0000, 1'b1, 1'b0);
    check("ovf.sticky", 64'(overflow), 64'h2);
    cyc(4'b0000, 1'b1, 1'b1);
    check("ovf.clr", 64'(overflow), 64'h0);
    // Set wins over clear on the same edge.
    sd[0] = 60'h6;
    cyc(4'b0001, 1'b0, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0);
    cyc(4'b0010, 1'b0, 1'b0);
    cyc(4'b0010, 1'b0, 1'b1);
    check("ovf.setwins", 64'(overflow), 64'h2);
    cyc(4'b0000, 1'b1, 1'b1);
    cyc(4'b0000, 1'b1, 1'b0);

    // Fairness: 0 and 3 re-flag every cycle; last grant was 1, so 3 goes first.
    sd[0] = 60'hA0;
    sd[3] = 60'hA3;
    cyc(4'b1001, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++) begin
      cyc(4'b1001, 1'b1, 1'b0);
      ids[k] = out_id;
    end
    for (int k = 0; k < 6; k++) check("fair.id", 64'(ids[k]), (k % 2 == 0) ? 64'd3 : 64'd0);
    cyc(4'b0000, 1'b1, 1'b1);
    cyc(4'b0000, 1'b1, 1'b0);
    cyc(4'b0000, 1'b1, 1'b0);

    // Reset mid-transfer, then first grant goes to source 0.
    cyc(4'b1111, 1'b0, 1'b0);
    cyc(4'b0010, 1'b0, 1'b0);
    check("mid.valid", 64'(out_valid), 64'd1);
    do_reset();
    sd[0] = 60'hB0;
    sd[1] = 60'hB1;
    cyc(4'b0011, 1'b1, 1'b0);
    cyc(4'b0000, 1'b1, 1'b0);
    check("post.id0",  64'(out_id), 64'd0);
    check("post.out0", 64'(out),    64'hB0);
    cyc(4'b0000, 1'b1, 1'b0);
    check("post.id1",  64'(out_id), 64'd1);
    check("post.out1", 64'(out),    64'hB1);
    cyc(4'b0000, 1'b1, 1'b0);
    check("post.idle", 64'(out_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
